// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: WIDTH-bit add/subtract through one shared 4-bit slice, LSB nibble first
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int KW = $clog2(NIBBLES) + 1;
    localparam int KI = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [KW-1:0] LAST = KW'(NIBBLES - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [NIBBLES-1:0][3:0] op_a, op_b, work;
    logic carry_reg;
    logic [KW-1:0] k;
    logic [KI-1:0] ki;
    logic [4:0] slice;
    always_comb begin
        ki = k[KI-1:0];
        slice = {1'b0, op_a[ki]} + {1'b0, op_b[ki]} + {4'b0, carry_reg};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            work      <= '0;
            carry_reg <= 1'b0;
            k         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    op_a      <= a;
                    op_b      <= sub ? ~b : b;
                    carry_reg <= sub | carry_in;
                    work      <= '0;
                    k         <= '0;
                    busy      <= 1'b1;
                    state     <= RUN;
                end
                RUN: begin
                    work[ki]  <= slice[3:0];
                    carry_reg <= slice[4];
                    k         <= k + 1'b1;
                    if (k == LAST) state <= DONE;
                end
                DONE: begin
                    // op_b already holds ~b when subtracting, so one overflow rule covers both modes
                    sum       <= work;
                    carry_out <= carry_reg;
                    overflow  <= (op_a[NIBBLES-1][3] == op_b[NIBBLES-1][3]) &&
                                 (work[NIBBLES-1][3] != op_a[NIBBLES-1][3]);
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
